// File: rtl/vol_sched_pkg.sv
// Shared widths and types for the volatility update scheduler.
// The DEF_* values are the standard build; the top derives its own widths
// from its parameters, so overriding them there stays self-consistent.
package vol_sched_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_BUFFER_SIZE = 32;
    localparam int DEF_NUM_STOCKS  = 4;

    localparam int STOCK_W = $clog2(DEF_NUM_STOCKS);
    localparam int PTR_W   = $clog2(DEF_BUFFER_SIZE);
    localparam int ADDR_W  = STOCK_W + PTR_W;

    typedef logic [STOCK_W-1:0] stock_id_t;
    typedef logic [PTR_W-1:0]   ptr_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] ask;
        logic [DEF_DATA_WIDTH-1:0] bid;
    } quote_t;

endpackage

// File: rtl/volatility_update_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational search over req starting at ptr.
// Ports:
//   req     - request vector
//   ptr     - index with highest priority this cycle
//   gnt     - one-hot grant
//   gnt_idx - index of the granted requester
//   gnt_any - a grant was made
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            // N is a power of two, so the IW-bit add wraps modulo N.
            idx = ptr + IW'(k);
            if (!gnt_any && req[idx]) begin
                gnt_any      = 1'b1;
                gnt_idx      = idx;
                gnt[idx]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/volatility_update_scheduler.sv
// Front-end sequencer for the per-stock rolling volatility datapath.
// Holds one latest-wins quote slot per stock, round-robin issues pending
// slots onto the single datapath port, owns the per-stock circular write
// pointers and fill counters, and checks datapath completions.
// Ports:
//   i_clk, i_reset_n        clock, synchronous active-low reset
//   i_req_valid/best_*      per-stock quote updates (packed per stock)
//   o_req_ready             all-1 out of reset
//   o_coalesced             pulse: a still-pending quote was overwritten
//   o_vm_*                  registered issue to the datapath
//   i_vm_data_valid         datapath completion, expected 1 cycle after issue
//   o_stock_warm            stock window full
//   o_protocol_error        sticky completion mismatch
module volatility_update_scheduler
    import vol_sched_pkg::*;
#(
    parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int  BUFFER_SIZE = DEF_BUFFER_SIZE,
    parameter int  NUM_STOCKS  = DEF_NUM_STOCKS,
    localparam int SW = $clog2(NUM_STOCKS),
    localparam int PW = $clog2(BUFFER_SIZE),
    localparam int AW = SW + PW
) (
    input  logic                             i_clk,
    input  logic                             i_reset_n,
    input  logic [NUM_STOCKS-1:0]            i_req_valid,
    input  logic [NUM_STOCKS*DATA_WIDTH-1:0] i_req_best_ask,
    input  logic [NUM_STOCKS*DATA_WIDTH-1:0] i_req_best_bid,
    output logic [NUM_STOCKS-1:0]            o_req_ready,
    output logic [NUM_STOCKS-1:0]            o_coalesced,
    output logic                             o_vm_valid,
    output logic [SW-1:0]                    o_vm_stock_id,
    output logic [AW-1:0]                    o_vm_write_address,
    output logic [DATA_WIDTH-1:0]            o_vm_best_ask,
    output logic [DATA_WIDTH-1:0]            o_vm_best_bid,
    input  logic                             i_vm_data_valid,
    output logic [NUM_STOCKS-1:0]            o_stock_warm,
    output logic                             o_protocol_error
);

    localparam logic [PW:0] FULL = (PW+1)'(BUFFER_SIZE);

    logic [DATA_WIDTH-1:0] slot_ask [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] slot_bid [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] pending;
    logic [PW-1:0]         wr_ptr   [NUM_STOCKS];
    logic [PW:0]           fill     [NUM_STOCKS];
    logic [SW-1:0]         rr_ptr;

    logic [NUM_STOCKS-1:0] gnt_oh;
    logic [SW-1:0]         gnt_idx;
    logic                  gnt_any;

    // vld_pipe[0] is the issue strobe, vld_pipe[1] the completion expected now.
    logic [1:0]            vld_pipe;

    assign o_vm_valid = vld_pipe[0];

    rr_arbiter #(.N(NUM_STOCKS)) u_arb (
        .req     (pending),
        .ptr     (rr_ptr),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_req_ready        <= '0;
            o_coalesced        <= '0;
            o_vm_stock_id      <= '0;
            o_vm_write_address <= '0;
            o_vm_best_ask      <= '0;
            o_vm_best_bid      <= '0;
            o_stock_warm       <= '0;
            o_protocol_error   <= 1'b0;
            vld_pipe           <= '0;
            pending            <= '0;
            rr_ptr             <= '0;
            for (int s = 0; s < NUM_STOCKS; s++) begin
                slot_ask[s] <= '0;
                slot_bid[s] <= '0;
                wr_ptr[s]   <= '0;
                fill[s]     <= '0;
            end
        end else begin
            o_req_ready <= '1;
            vld_pipe    <= {vld_pipe[0], gnt_any};

            if (gnt_any) begin
                o_vm_stock_id      <= gnt_idx;
                o_vm_write_address <= {gnt_idx, wr_ptr[gnt_idx]};
                o_vm_best_ask      <= slot_ask[gnt_idx];
                o_vm_best_bid      <= slot_bid[gnt_idx];
                wr_ptr[gnt_idx]    <= wr_ptr[gnt_idx] + 1'b1;
                if (fill[gnt_idx] != FULL)
                    fill[gnt_idx] <= fill[gnt_idx] + 1'b1;
                rr_ptr <= gnt_idx + 1'b1;
            end

            for (int s = 0; s < NUM_STOCKS; s++) begin
                // A rewrite in the grant cycle keeps the slot pending with the
                // new quote; the granted (old) quote has already been issued.
                if (i_req_valid[s]) begin
                    slot_ask[s] <= i_req_best_ask[s*DATA_WIDTH +: DATA_WIDTH];
                    slot_bid[s] <= i_req_best_bid[s*DATA_WIDTH +: DATA_WIDTH];
                    pending[s]  <= 1'b1;
                end else if (gnt_oh[s]) begin
                    pending[s]  <= 1'b0;
                end
                o_coalesced[s]  <= i_req_valid[s] & pending[s] & ~gnt_oh[s];
                o_stock_warm[s] <= (fill[s] == FULL);
            end

            if (i_vm_data_valid != vld_pipe[1])
                o_protocol_error <= 1'b1;
        end
    end

endmodule
